multi_mode_stopwatch: RTL and testbench
=======================================

MULTI_MODE_STOPWATCH -- requirements
Module: multi_mode_stopwatch

Interface
REQ-001 The block SHALL have parameter TICK_DIV, default 100000000, giving clock cycles per counted second (minimum 1).
REQ-002 The block SHALL have parameter MIN_W, default 8, giving the minutes counter width.
REQ-003 The block SHALL have parameter LAP_DEPTH, default 4, giving lap FIFO entries (power of two, minimum 2).
REQ-004 clk  in  1  the single clock; all state SHALL update on its rising edge.
REQ-005 rst_n  in  1  reset, synchronous and active-low.
REQ-006 start, stop, reset  in  1 each  one-cycle command pulses.
REQ-007 lap  in  1  one-cycle pulse that captures the current time.
REQ-008 mode  in  1  count direction: 0 = up, 1 = down.
REQ-009 load  in  1  one-cycle pulse that presets the time from load_min and load_sec.
REQ-010 load_min  in  MIN_W and load_sec  in  6  preset value; load_sec values above 59 SHALL be clamped to 59.
REQ-011 minutes  out  MIN_W and seconds  out  6  current registered time.
REQ-012 status  out  2  state: 00 IDLE, 01 RUNNING, 10 PAUSED, 11 EXPIRED.
REQ-013 expired  out  1  one-cycle pulse on reaching 0:00 in down mode.
REQ-014 lap_rd  in  1  pops the lap FIFO head when lap_valid is high.
REQ-015 lap_valid  out  1, lap_min  out  MIN_W, lap_sec  out  6  show the FIFO head (show-ahead).
REQ-016 lap_full  out  1  FIFO holds LAP_DEPTH entries.

Function
REQ-017 Commands SHALL have fixed priority: reset > stop > start > load; lap and lap_rd SHALL be processed independently of the commands.
REQ-018 In IDLE, start SHALL latch mode into the internal direction register, clear the prescaler and enter RUNNING on the next cycle. Exception: in down mode at 0:00, start SHALL be ignored.
REQ-019 The mode input SHALL be ignored outside IDLE.
REQ-020 In RUNNING, the prescaler SHALL count 0..TICK_DIV-1. The time SHALL update in the cycle the prescaler wraps, so the first second is counted exactly TICK_DIV cycles after entering RUNNING.
REQ-021 In RUNNING, stop SHALL enter PAUSED with the time and prescaler frozen.
REQ-022 In PAUSED, start SHALL resume RUNNING with the prescaler value preserved.
REQ-023 Up counting: seconds 59 SHALL roll to 0 and increment minutes. At (2^MIN_W-1):59 the time SHALL wrap to 0:00 and remain RUNNING.
REQ-024 Down counting: seconds 0 SHALL roll to 59 and decrement minutes. A tick at 0:01 SHALL produce 0:00, assert expired for exactly that next cycle, and enter EXPIRED with the prescaler stopped.
REQ-025 In EXPIRED, only reset and load SHALL be honoured. Either one SHALL enter IDLE.
REQ-026 load SHALL be honoured only in IDLE, PAUSED or EXPIRED. It SHALL update the time on the next cycle and leave the state unchanged, except that in EXPIRED it enters IDLE.
REQ-027 A soft reset pulse SHALL, on the next cycle, set the time to 0:00, clear the prescaler, empty the FIFO and enter IDLE, from any state.
REQ-028 lap in RUNNING or PAUSED SHALL push the pre-update time of that cycle.
REQ-029 lap SHALL be ignored in IDLE and EXPIRED, and when lap_full is high unless lap_rd pops in the same cycle.
REQ-030 A simultaneous push and pop SHALL keep the occupancy unchanged. lap_rd while lap_valid is low SHALL be ignored.
REQ-031 All outputs SHALL be registered. Command effects SHALL be visible one cycle after the pulse.

Reset
REQ-032 While rst_n is low at a clock edge, the block SHALL set status=00, minutes=0, seconds=0, expired=0, lap_valid=0, lap_full=0, lap_min=0, lap_sec=0, prescaler=0 and direction=up.
REQ-033 rst_n low SHALL override every command, including commands arriving mid-count or mid-expiry.

Structure
REQ-034 Package stopwatch_pkg SHALL hold the status encodings IDLE, RUNNING, PAUSED and EXPIRED, and the constants SEC_MAX=59 and SEC_W=6.
REQ-035 The lap storage SHALL be one sub-module, lap_fifo, parametrised by depth and data width (MIN_W+6), with push, pop, flush, valid and full.

Verification
REQ-036 With TICK_DIV=1: release reset, pulse start, wait 130 cycles, pulse stop -> status=10 and time 2:10, frozen over the next 50 cycles.
REQ-037 With TICK_DIV=4: pause 3 cycles into a second, resume, then run -> the next second completes exactly 1 cycle after resume.
REQ-038 Down mode with TICK_DIV=1: load 0:03 then start -> expired pulses once after 3 ticks, status=11 and time 0:00 is held. A following start is ignored, and a load of 0:05 returns status to 00.
REQ-039 Up mode with MIN_W=2: load 3:58 and run 2 ticks -> 0:00 with status still 01.
REQ-040 Laps: push 5 laps into depth 4 -> the 5th is dropped and lap_full=1. A simultaneous lap and lap_rd while full -> occupancy stays 4, and reads return times in capture order.
REQ-041 Priority and reset: start, stop and reset in the same cycle -> IDLE at 0:00. rst_n low mid-run -> all outputs reach their reset values on the next edge.

Source files
------------

// File: rtl/stopwatch_pkg.sv
// -----------------------------------------------------------------------------
// stopwatch_pkg
//   Shared definitions for the multi-mode stopwatch: the externally visible
//   status encodings, the seconds field geometry and a small helper that
//   saturates a preset seconds value into the legal 0..59 range.
// -----------------------------------------------------------------------------
package stopwatch_pkg;

  // Encodings are visible on the status port, so the values are fixed.
  typedef enum logic [1:0] {
    IDLE    = 2'b00,
    RUNNING = 2'b01,
    PAUSED  = 2'b10,
    EXPIRED = 2'b11
  } status_e;

  localparam int                SEC_W   = 6;
  localparam logic [SEC_W-1:0]  SEC_MAX = SEC_W'(59);

  // Preset seconds above 59 saturate rather than wrap.
  function automatic logic [SEC_W-1:0] clamp_sec(input logic [SEC_W-1:0] sec);
    return (sec > SEC_MAX) ? SEC_MAX : sec;
  endfunction

endpackage

// File: rtl/lap_fifo.sv
// -----------------------------------------------------------------------------
// lap_fifo
//   Show-ahead FIFO holding captured lap times. The head entry, valid and full
//   flags are all registered so the outputs change only on a clock edge.
//
//   Ports
//     clk, rst_n   clock and synchronous active-low reset
//     push         write push_data (dropped when full unless pop is accepted)
//     pop          discard the head entry (ignored when empty)
//     flush        empty the FIFO on the next edge (wins over push/pop)
//     push_data    entry to write
//     valid        FIFO holds at least one entry; head is meaningful
//     full         FIFO holds DEPTH entries
//     head         oldest entry (zero when empty)
// -----------------------------------------------------------------------------
module lap_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 14
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic             pop,
  input  logic             flush,
  input  logic [WIDTH-1:0] push_data,
  output logic             valid,
  output logic             full,
  output logic [WIDTH-1:0] head
);

  localparam int               PTR_W   = $clog2(DEPTH);
  localparam int               CNT_W   = PTR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] rd_ptr, wr_ptr, rd_nxt, wr_nxt;
  logic [CNT_W-1:0] count, count_nxt, remain;
  logic             do_pop, do_push;
  logic [WIDTH-1:0] head_nxt;

  always_comb begin
    // NOTE: every signal assigned here gets a value on every path (default
    // first), otherwise synthesis infers a latch to hold the old value.
    head_nxt  = '0;
    do_pop    = pop && (count != '0);
    // A pop in the same cycle frees the slot, so a full FIFO still accepts.
    do_push   = push && ((count != DEPTH_C) || do_pop);
    remain    = count - CNT_W'(do_pop);
    count_nxt = remain + CNT_W'(do_push);
    rd_nxt    = rd_ptr + PTR_W'(do_pop);
    wr_nxt    = wr_ptr + PTR_W'(do_push);
    // The registered head must already show the entry that becomes oldest:
    // the incoming word if nothing else remains, otherwise the stored entry.
    if (count_nxt != '0) begin
      if (remain == '0) head_nxt = push_data;
      else              head_nxt = mem[rd_nxt];
    end
  end

  // NOTE: the storage array has no reset; its contents are only observable
  // through head, which is gated by the count, so clearing it buys nothing.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values regardless of statement order.
    if (!rst_n || flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      valid  <= 1'b0;
      full   <= 1'b0;
      head   <= '0;
    end else begin
      rd_ptr <= rd_nxt;
      wr_ptr <= wr_nxt;
      count  <= count_nxt;
      valid  <= (count_nxt != '0);
      full   <= (count_nxt == DEPTH_C);
      head   <= head_nxt;
    end
  end

endmodule

// File: rtl/multi_mode_stopwatch.sv
// -----------------------------------------------------------------------------
// multi_mode_stopwatch
//   Minutes:seconds stopwatch counting up or down, with pause/resume, preset
//   load, expiry detection in down mode and a FIFO of captured lap times.
//
//   Parameters
//     TICK_DIV   clock cycles per counted second (>= 1)
//     MIN_W      minutes counter width
//     LAP_DEPTH  lap FIFO entries (power of two, >= 2)
//
//   Ports
//     clk, rst_n              clock and synchronous active-low reset
//     start, stop, reset      command pulses, priority reset > stop > start > load
//     load, load_min/sec      preset pulse and value (seconds clamp to 59)
//     mode                    direction sampled on start from IDLE: 0 up, 1 down
//     lap                     capture the current time into the lap FIFO
//     minutes, seconds        current time (registered)
//     status                  IDLE / RUNNING / PAUSED / EXPIRED
//     expired                 one-cycle pulse when a down count reaches 0:00
//     lap_rd                  pop the lap FIFO head
//     lap_valid/min/sec/full  lap FIFO head and flags (show-ahead)
// -----------------------------------------------------------------------------
module multi_mode_stopwatch
  import stopwatch_pkg::*;
#(
  parameter int TICK_DIV  = 100000000,
  parameter int MIN_W     = 8,
  parameter int LAP_DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             stop,
  input  logic             reset,
  input  logic             lap,
  input  logic             mode,
  input  logic             load,
  input  logic [MIN_W-1:0] load_min,
  input  logic [SEC_W-1:0] load_sec,
  output logic [MIN_W-1:0] minutes,
  output logic [SEC_W-1:0] seconds,
  output logic [1:0]       status,
  output logic             expired,
  input  logic             lap_rd,
  output logic             lap_valid,
  output logic [MIN_W-1:0] lap_min,
  output logic [SEC_W-1:0] lap_sec,
  output logic             lap_full
);

  localparam int               PRE_W    = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(TICK_DIV - 1);

  status_e                  state;
  logic [PRE_W-1:0]         prescaler;
  logic                     dir_down;
  logic                     time_zero;
  logic                     advance;
  logic                     tick;
  logic                     lap_push;
  logic [MIN_W+SEC_W-1:0]   lap_head;

  always_comb begin
    time_zero = (minutes == '0) && (seconds == '0);
    // Start and load have no effect while running, so only reset and stop
    // can interrupt the prescaler in RUNNING.
    advance   = (state == RUNNING) && !reset && !stop;
    tick      = advance && (prescaler == PRE_LAST);
    lap_push  = lap && ((state == RUNNING) || (state == PAUSED));
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      minutes   <= '0;
      seconds   <= '0;
      prescaler <= '0;
      dir_down  <= 1'b0;
      expired   <= 1'b0;
    end else begin
      expired <= 1'b0;

      if (reset) begin
        state     <= IDLE;
        minutes   <= '0;
        seconds   <= '0;
        prescaler <= '0;
      end else if (stop) begin
        if (state == RUNNING) state <= PAUSED;
      end else if (start) begin
        // A down count from 0:00 would expire immediately, so it never starts.
        if ((state == IDLE) && !(mode && time_zero)) begin
          dir_down  <= mode;
          prescaler <= '0;
          state     <= RUNNING;
        end else if (state == PAUSED) begin
          state <= RUNNING;
        end
      end else if (load) begin
        if (state != RUNNING) begin
          minutes <= load_min;
          seconds <= clamp_sec(load_sec);
          if (state == EXPIRED) state <= IDLE;
        end
      end

      // The time moves in the cycle the prescaler wraps, so the first second
      // completes TICK_DIV cycles after entering RUNNING.
      if (advance) begin
        if (tick) begin
          prescaler <= '0;
          if (!dir_down) begin
            if (seconds == SEC_MAX) begin
              seconds <= '0;
              minutes <= minutes + MIN_W'(1);
            end else begin
              seconds <= seconds + SEC_W'(1);
            end
          end else begin
            if (seconds == '0) begin
              seconds <= SEC_MAX;
              minutes <= minutes - MIN_W'(1);
            end else begin
              seconds <= seconds - SEC_W'(1);
              if ((minutes == '0) && (seconds == SEC_W'(1))) begin
                expired <= 1'b1;
                state   <= EXPIRED;
              end
            end
          end
        end else begin
          prescaler <= prescaler + PRE_W'(1);
        end
      end
    end
  end

  assign status = state;

  // Laps capture the time as it stood before this edge's update.
  lap_fifo #(
    .DEPTH (LAP_DEPTH),
    .WIDTH (MIN_W + SEC_W)
  ) u_lap_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (lap_push),
    .pop       (lap_rd),
    .flush     (reset),
    .push_data ({minutes, seconds}),
    .valid     (lap_valid),
    .full      (lap_full),
    .head      (lap_head)
  );

  assign lap_min = lap_head[SEC_W +: MIN_W];
  assign lap_sec = lap_head[SEC_W-1:0];

endmodule

// File: tb/tb_multi_mode_stopwatch.sv
// -----------------------------------------------------------------------------
// tb_multi_mode_stopwatch
//   Two stopwatch instances share one stimulus stream:
//     dut_a  TICK_DIV=1, MIN_W=8
//     dut_b  TICK_DIV=4, MIN_W=2
//   Each is tracked by a reference model that keeps the time as a total
//   number of seconds and the laps in a queue.
// -----------------------------------------------------------------------------
module tb_multi_mode_stopwatch;

  localparam int DEPTH = 4;
  localparam int S_IDLE = 0, S_RUN = 1, S_PAU = 2, S_EXP = 3;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0, stop = 1'b0, reset = 1'b0, lap = 1'b0;
  logic       mode = 1'b0, load = 1'b0, lap_rd = 1'b0;
  logic [7:0] load_min = '0;
  logic [5:0] load_sec = '0;

  logic [7:0] a_min, a_lap_min;
  logic [5:0] a_sec, a_lap_sec;
  logic [1:0] a_status;
  logic       a_expired, a_lap_valid, a_lap_full;

  logic [1:0] b_min, b_lap_min;
  logic [5:0] b_sec, b_lap_sec;
  logic [1:0] b_status;
  logic       b_expired, b_lap_valid, b_lap_full;

  int checks = 0;
  int failures = 0;

  multi_mode_stopwatch #(.TICK_DIV(1), .MIN_W(8), .LAP_DEPTH(DEPTH)) dut_a (
    .clk(clk), .rst_n(rst_n), .start(start), .stop(stop), .reset(reset),
    .lap(lap), .mode(mode), .load(load), .load_min(load_min), .load_sec(load_sec),
    .minutes(a_min), .seconds(a_sec), .status(a_status), .expired(a_expired),
    .lap_rd(lap_rd), .lap_valid(a_lap_valid), .lap_min(a_lap_min),
    .lap_sec(a_lap_sec), .lap_full(a_lap_full)
  );

  multi_mode_stopwatch #(.TICK_DIV(4), .MIN_W(2), .LAP_DEPTH(DEPTH)) dut_b (
    .clk(clk), .rst_n(rst_n), .start(start), .stop(stop), .reset(reset),
    .lap(lap), .mode(mode), .load(load), .load_min(load_min[1:0]), .load_sec(load_sec),
    .minutes(b_min), .seconds(b_sec), .status(b_status), .expired(b_expired),
    .lap_rd(lap_rd), .lap_valid(b_lap_valid), .lap_min(b_lap_min),
    .lap_sec(b_lap_sec), .lap_full(b_lap_full)
  );

  always #5 clk = ~clk;

  // Observed outputs packed for whole-state comparison; the lap head only
  // matters while valid.
  logic [39:0] a_vec, b_vec;
  logic [32:0] a_raw;
  logic [24:0] b_raw;
  assign a_vec = {a_status, a_min, a_sec, a_expired, a_lap_valid, a_lap_full, 7'd0,
                  (a_lap_valid ? {a_lap_min, a_lap_sec} : 14'd0)};
  assign b_vec = {b_status, 6'd0, b_min, b_sec, b_expired, b_lap_valid, b_lap_full, 7'd0,
                  (b_lap_valid ? {6'd0, b_lap_min, b_lap_sec} : 14'd0)};
  assign a_raw = {a_status, a_min, a_sec, a_expired, a_lap_valid, a_lap_full, a_lap_min, a_lap_sec};
  assign b_raw = {b_status, b_min, b_sec, b_expired, b_lap_valid, b_lap_full, b_lap_min, b_lap_sec};

  // ---------------- reference model (index 0 = dut_a, 1 = dut_b) -----------
  int td[2]   = '{1, 4};
  int mins[2] = '{256, 4};
  int m_t[2];     // time as total seconds
  int m_p[2];     // cycles elapsed in the current second
  int m_st[2];
  int m_dir[2];
  int m_exp[2];
  int m_q[2][$];

  task automatic model_step(input int i);
    int t0, st0, sz, span;
    bit do_pop, do_push;
    span = mins[i] * 60;
    m_exp[i] = 0;
    if (!rst_n) begin
      m_t[i] = 0; m_p[i] = 0; m_st[i] = S_IDLE; m_dir[i] = 0; m_q[i].delete();
      return;
    end
    if (reset) begin
      m_t[i] = 0; m_p[i] = 0; m_st[i] = S_IDLE; m_q[i].delete();
      return;
    end
    t0 = m_t[i]; st0 = m_st[i]; sz = m_q[i].size();
    do_pop  = lap_rd && (sz > 0);
    do_push = lap && (st0 == S_RUN || st0 == S_PAU) && (sz < DEPTH || do_pop);
    if (do_pop)  void'(m_q[i].pop_front());
    if (do_push) m_q[i].push_back(t0);
    if (stop) begin
      if (st0 == S_RUN) m_st[i] = S_PAU;
    end else if (start) begin
      if (st0 == S_IDLE && !(mode && t0 == 0)) begin
        m_dir[i] = int'(mode); m_p[i] = 0; m_st[i] = S_RUN;
      end else if (st0 == S_PAU) m_st[i] = S_RUN;
    end else if (load) begin
      if (st0 != S_RUN) begin
        m_t[i] = (int'(load_min) % mins[i]) * 60 + ((load_sec > 59) ? 59 : int'(load_sec));
        if (st0 == S_EXP) m_st[i] = S_IDLE;
      end
    end
    if (st0 == S_RUN && !stop) begin
      if (m_p[i] == td[i] - 1) begin
        m_p[i] = 0;
        if (m_dir[i] == 0) m_t[i] = (m_t[i] + 1) % span;
        else begin
          m_t[i] = (m_t[i] + span - 1) % span;
          if (m_t[i] == 0) begin m_exp[i] = 1; m_st[i] = S_EXP; end
        end
      end else m_p[i]++;
    end
  endtask

  function automatic logic [39:0] exp_vec(input int i);
    logic [39:0] v;
    int hd;
    v = '0;
    v[39:38] = 2'(m_st[i]);
    v[37:30] = 8'(m_t[i] / 60);
    v[29:24] = 6'(m_t[i] % 60);
    v[23]    = (m_exp[i] != 0);
    v[22]    = (m_q[i].size() > 0);
    v[21]    = (m_q[i].size() == DEPTH);
    if (m_q[i].size() > 0) begin
      hd = m_q[i][0];
      v[13:6] = 8'(hd / 60);
      v[5:0]  = 6'(hd % 60);
    end
    return v;
  endfunction

  // One clock: inputs held across the edge, model advanced, pulses dropped.
  task automatic cyc();
    @(posedge clk);
    model_step(0);
    model_step(1);
    #1;
    start = 0; stop = 0; reset = 0; lap = 0; load = 0; lap_rd = 0;
  endtask

  task automatic soft_reset();
    reset = 1;
    cyc();
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst_n = 0;
    repeat (2) cyc();
    checks++;
    if (a_raw !== '0) begin failures++; $display("FAIL reset_a: got %h want 0", a_raw); end
    checks++;
    if (b_raw !== '0) begin failures++; $display("FAIL reset_b: got %h want 0", b_raw); end
    rst_n = 1;
    cyc();
  endtask

  task automatic test_run_stop();
    bit frozen;
    soft_reset();
    mode = 0; start = 1; cyc();
    repeat (130) cyc();
    stop = 1; cyc();
    checks++;
    if ({a_status, a_min, a_sec} !== {2'b10, 8'd2, 6'd10}) begin
      failures++;
      $display("FAIL run_stop: got st=%0d %0d:%0d want st=2 2:10", a_status, a_min, a_sec);
    end
    frozen = 1;
    for (int k = 0; k < 50; k++) begin
      cyc();
      if ({a_status, a_min, a_sec} !== {2'b10, 8'd2, 6'd10}) frozen = 0;
    end
    checks++;
    if (frozen !== 1'b1) begin failures++; $display("FAIL pause_frozen: got %0d want 1", frozen); end
  endtask

  task automatic test_pause_resume();
    soft_reset();
    mode = 0; start = 1; cyc();
    repeat (3) cyc();
    stop = 1; cyc();
    repeat (5) cyc();
    checks++;
    if ({b_status, b_sec} !== {2'b10, 6'd0}) begin
      failures++; $display("FAIL paused_b: got st=%0d s=%0d want st=2 s=0", b_status, b_sec);
    end
    start = 1; cyc();
    checks++;
    if ({b_status, b_sec} !== {2'b01, 6'd0}) begin
      failures++; $display("FAIL resume_b: got st=%0d s=%0d want st=1 s=0", b_status, b_sec);
    end
    cyc();
    checks++;
    if (b_sec !== 6'd1) begin failures++; $display("FAIL resume_tick: got %0d want 1", b_sec); end
    repeat (4) cyc();
    checks++;
    if (b_sec !== 6'd2) begin failures++; $display("FAIL next_second: got %0d want 2", b_sec); end
  endtask

  task automatic test_down_expire();
    int pulses, at;
    soft_reset();
    mode = 1; start = 1; cyc();
    checks++;
    if (a_status !== 2'b00) begin failures++; $display("FAIL start_at_zero: got %0d want 0", a_status); end
    load_min = 0; load_sec = 3; load = 1; cyc();
    start = 1; cyc();
    pulses = 0; at = -1;
    for (int k = 1; k <= 8; k++) begin
      cyc();
      if (a_expired === 1'b1) begin pulses++; at = k; end
    end
    checks++;
    if (pulses != 1 || at != 3) begin
      failures++; $display("FAIL expire_pulse: got %0d pulses at %0d want 1 at 3", pulses, at);
    end
    checks++;
    if ({a_status, a_min, a_sec} !== {2'b11, 8'd0, 6'd0}) begin
      failures++; $display("FAIL expired_hold: got st=%0d %0d:%0d want st=3 0:0", a_status, a_min, a_sec);
    end
    start = 1; cyc();
    checks++;
    if (a_status !== 2'b11) begin failures++; $display("FAIL start_in_expired: got %0d want 3", a_status); end
    load_min = 0; load_sec = 5; load = 1; cyc();
    checks++;
    if ({a_status, a_min, a_sec} !== {2'b00, 8'd0, 6'd5}) begin
      failures++; $display("FAIL load_from_expired: got st=%0d %0d:%0d want st=0 0:5", a_status, a_min, a_sec);
    end
    mode = 0;
  endtask

  task automatic test_wrap_and_clamp();
    soft_reset();
    load_min = 3; load_sec = 58; load = 1; cyc();
    mode = 0; start = 1; cyc();
    repeat (4) cyc();
    checks++;
    if ({b_min, b_sec} !== {2'd3, 6'd59}) begin
      failures++; $display("FAIL wrap_pre: got %0d:%0d want 3:59", b_min, b_sec);
    end
    repeat (4) cyc();
    checks++;
    if ({b_status, b_min, b_sec} !== {2'b01, 2'd0, 6'd0}) begin
      failures++; $display("FAIL wrap: got st=%0d %0d:%0d want st=1 0:0", b_status, b_min, b_sec);
    end
    soft_reset();
    load_min = 1; load_sec = 63; load = 1; cyc();
    checks++;
    if ({a_min, a_sec, b_min, b_sec} !== {8'd1, 6'd59, 2'd1, 6'd59}) begin
      failures++; $display("FAIL clamp: got %0d:%0d / %0d:%0d want 1:59 / 1:59", a_min, a_sec, b_min, b_sec);
    end
  endtask

  task automatic test_laps();
    int lap_exp[4] = '{1, 2, 3, 5};
    soft_reset();
    mode = 0; start = 1; cyc();
    for (int k = 0; k < 5; k++) begin lap = 1; cyc(); end
    checks++;
    if ({a_lap_full, a_lap_valid, a_lap_min, a_lap_sec} !== {1'b1, 1'b1, 8'd0, 6'd0}) begin
      failures++; $display("FAIL lap_fill: got full=%0d valid=%0d head=%0d:%0d want 1 1 0:0",
                           a_lap_full, a_lap_valid, a_lap_min, a_lap_sec);
    end
    lap = 1; lap_rd = 1; cyc();
    checks++;
    if (a_lap_full !== 1'b1) begin failures++; $display("FAIL lap_push_pop_full: got %0d want 1", a_lap_full); end
    stop = 1; cyc();
    for (int k = 0; k < 4; k++) begin
      checks++;
      if ({a_lap_valid, a_lap_min, a_lap_sec} !== {1'b1, 8'd0, 6'(lap_exp[k])}) begin
        failures++; $display("FAIL lap_read%0d: got valid=%0d %0d:%0d want 1 0:%0d",
                             k, a_lap_valid, a_lap_min, a_lap_sec, lap_exp[k]);
      end
      lap_rd = 1; cyc();
    end
    checks++;
    if ({a_lap_valid, a_lap_full} !== 2'b00) begin
      failures++; $display("FAIL lap_drained: got %b want 00", {a_lap_valid, a_lap_full});
    end
  endtask

  task automatic test_priority_and_rst();
    soft_reset();
    mode = 0; start = 1; cyc();
    repeat (5) cyc();
    start = 1; stop = 1; reset = 1; cyc();
    checks++;
    if ({a_status, a_min, a_sec} !== {2'b00, 8'd0, 6'd0}) begin
      failures++; $display("FAIL priority: got st=%0d %0d:%0d want st=0 0:0", a_status, a_min, a_sec);
    end
    start = 1; cyc();
    lap = 1; cyc();
    repeat (3) cyc();
    rst_n = 0; start = 1; lap = 1; cyc();
    checks++;
    if (a_raw !== '0) begin failures++; $display("FAIL rst_mid_run_a: got %h want 0", a_raw); end
    checks++;
    if (b_raw !== '0) begin failures++; $display("FAIL rst_mid_run_b: got %h want 0", b_raw); end
    rst_n = 1; cyc();
  endtask

  task automatic test_random();
    int c;
    logic [39:0] ea, eb;
    for (int n = 0; n < 2500; n++) begin
      rst_n = ($urandom_range(0, 999) < 3) ? 1'b0 : 1'b1;
      c = $urandom_range(0, 99);
      if      (c < 2)  reset = 1;
      else if (c < 8)  stop  = 1;
      else if (c < 18) start = 1;
      else if (c < 24) load  = 1;
      mode     = 1'($urandom_range(0, 1));
      load_min = 8'($urandom_range(0, 255));
      load_sec = 6'($urandom_range(0, 63));
      lap      = ($urandom_range(0, 99) < 25);
      lap_rd   = ($urandom_range(0, 99) < 20);
      cyc();
      rst_n = 1;
      ea = exp_vec(0);
      eb = exp_vec(1);
      checks++;
      if (a_vec !== ea) begin failures++; $display("FAIL rand_a cycle %0d: got %h want %h", n, a_vec, ea); end
      checks++;
      if (b_vec !== eb) begin failures++; $display("FAIL rand_b cycle %0d: got %h want %h", n, b_vec, eb); end
    end
  endtask

  initial begin
    test_reset();
    test_run_stop();
    test_pause_resume();
    test_down_expire();
    test_wrap_and_clamp();
    test_laps();
    test_priority_and_rst();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
